ex_scoreboard: RTL
==================

Name: ex_scoreboard

Overview:
- Parametrised register scoreboard and hazard unit for the EX stage.
- Tracks destination registers owned by N long-latency writeback channels, e.g. ch0 = LOAD, ch1 = MULT, ch2 = DIV.
- Stalls issue on RAW/WAW hazards and when a channel's outstanding-depth limit is reached.
- Supports per-channel flush, for example when MEM flushes in-flight loads.

Parameters:
- REG_NUM, 32: number of architectural registers; x0 is never tracked.
- IDX_W, 5: register index width; must satisfy 2^IDX_W >= REG_NUM.
- LONG_CH, 3: number of long-latency writeback channels.
- CH_W, 2: channel-id width; must satisfy 2^CH_W >= LONG_CH.
- MAX_OUT, 4: maximum outstanding writes per channel, range 1..15.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- instruction_vld  in  1  instruction presented in EX this cycle
- rs1_index  in  IDX_W  source 1 index
- rs2_index  in  IDX_W  source 2 index
- rd_index  in  IDX_W  destination index
- rs1_mark  in  1  instruction reads rs1
- rs2_mark  in  1  instruction reads rs2
- rd_mark  in  1  instruction writes rd through the single-cycle EXE path
- rd_long_mark  in  1  instruction writes rd through a long channel
- long_ch  in  CH_W  target channel when rd_long_mark=1
- conflict  out  1  stall request; EXE_ready = !conflict
- wb_wr  in  LONG_CH  per-channel writeback strobe
- wb_rd  in  LONG_CH*IDX_W  per-channel writeback index; channel k occupies bits [k*IDX_W +: IDX_W]
- ch_flush  in  LONG_CH  per-channel flush
- busy_vec  out  REG_NUM  registered busy bit per register
- ch_full  out  LONG_CH  count[k] == MAX_OUT

Behaviour:
- Reset (rstn low, asynchronous):
  - busy, owner and counts all clear to 0.
  - busy_vec = 0, ch_full = 0.
  - conflict is 0 because it is qualified by instruction_vld.
- State:
  - busy[r] and owner[r] (CH_W bits) for r = 1..REG_NUM-1; busy[0] is tied to 0.
  - count[k] per channel, width clog2(MAX_OUT+1).
- conflict is combinational and is the OR of the following terms, all ANDed with instruction_vld:
  - RAW on rs1: rs1_mark & busy[rs1_index].
  - RAW on rs2: rs2_mark & busy[rs2_index].
  - WAW: (rd_mark | rd_long_mark) & busy[rd_index].
  - Channel full: rd_long_mark & ch_full[long_ch].
  - Flush pending: rd_long_mark & ch_flush[long_ch].
  - Illegal channel: rd_long_mark & (long_ch >= LONG_CH); the instruction stalls forever, which verification flags as an assertion.
- Issue: issue = instruction_vld & !conflict & rd_long_mark.
  - With rd_index != 0: next cycle busy[rd] = 1, owner[rd] = long_ch, and count[long_ch] increments.
  - With rd_index == 0: count[long_ch] still increments, because the result still returns; busy is not set.
- Writeback on channel k (wb_wr[k] = 1, rd = wb_rd slice):
  - If busy[rd] and owner[rd] == k, busy[rd] clears next cycle.
  - count[k] decrements, saturating at 0.
  - A writeback to rd = 0 or to an unowned register only decrements the count.
- Simultaneous events in one cycle:
  - Multiple channels write back: each is processed independently; only the owner clears a register.
  - Issue and writeback on the same channel: the count is unchanged.
  - Issue to reg r and writeback clearing r: the issue wins (busy stays 1, owner updated). This cannot occur for the same r without the bypass feature, because WAW already stalls.
- Flush of channel k (ch_flush[k] = 1):
  - Next cycle, every busy register with owner == k clears and count[k] = 0.
  - wb_wr[k] in the same cycle is ignored.
  - Other channels are unaffected.
- Latency: all state updates are one cycle after the clock edge; busy_vec and ch_full are registered views of that state.
- x0 is never busy, so it never causes a stall.

Optional Feature:
- SCB_WB_BYPASS_EN defined:
  - A same-cycle valid owning writeback (wb_wr[k], wb_rd == r, owner[r] == k, not flushed) masks busy[r] in the RAW/WAW terms of conflict.
  - The register file is required to forward the same-cycle write data.
  - A same-cycle decrement of count[k] also masks ch_full[k] in the channel-full conflict term.
- Undefined: conflict uses registered state only, which costs one extra stall cycle after each writeback.

Test Plan:
- LOAD issue rd=5 on ch0, next instr rs1=5 -> conflict=1 until the cycle after wb_wr[0] with wb_rd=5; busy_vec[5] goes 1 then 0 (with bypass: conflict drops in the wb cycle).
- Four MULT issues rd=1..4 on ch1 with MAX_OUT=4 -> ch_full[1]=1; a fifth ch1 issue stalls; one ch1 writeback -> issue proceeds next cycle.
- Loads to rd=6,7 on ch0 with a DIV to rd=8 on ch2, then ch_flush[0] -> busy_vec[6], busy_vec[7] clear, busy_vec[8] stays 1, count[0]=0.
- wb_wr[2] with wb_rd=9 while reg 9 is owned by ch0 -> busy_vec[9] stays 1; count[2] decrements (saturating at 0).
- rd_long_mark issue to rd=0 -> busy_vec[0]=0, count increments, and a later rs1=0 read never stalls.
- Assert rstn low mid-operation with several busy registers -> busy_vec=0, ch_full=0 immediately (asynchronous); conflict=0 on the next valid instruction.

Source files
------------

// File: rtl/ex_scoreboard.sv
// EX-stage register scoreboard: tracks registers owned by long-latency writeback channels
// and raises conflict on RAW/WAW, channel-full, flush-pending and illegal-channel cases.
// Optional same-cycle writeback bypass of the hazard terms: define SCB_WB_BYPASS_EN.
module ex_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int IDX_W   = 5,
  parameter int LONG_CH = 3,
  parameter int CH_W    = 2,
  parameter int MAX_OUT = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     instruction_vld,
  input  logic [IDX_W-1:0]         rs1_index,
  input  logic [IDX_W-1:0]         rs2_index,
  input  logic [IDX_W-1:0]         rd_index,
  input  logic                     rs1_mark,
  input  logic                     rs2_mark,
  input  logic                     rd_mark,
  input  logic                     rd_long_mark,
  input  logic [CH_W-1:0]          long_ch,
  output logic                     conflict,
  input  logic [LONG_CH-1:0]       wb_wr,
  input  logic [LONG_CH*IDX_W-1:0] wb_rd,
  input  logic [LONG_CH-1:0]       ch_flush,
  output logic [REG_NUM-1:0]       busy_vec,
  output logic [LONG_CH-1:0]       ch_full
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int IDX_N = 2 ** IDX_W;
  localparam int CH_N  = 2 ** CH_W;

  logic [REG_NUM-1:0] busy_reg, busy_next;
  logic [CH_W-1:0]    owner_reg  [REG_NUM];
  logic [CH_W-1:0]    owner_next [REG_NUM];
  logic [CNT_W-1:0]   count_reg  [LONG_CH];
  logic [CNT_W-1:0]   count_next [LONG_CH];

  logic [IDX_W-1:0]   wb_idx [LONG_CH];
  logic [LONG_CH-1:0] wb_own;
  logic [LONG_CH-1:0] dec_now;
  logic [IDX_N-1:0]   busy_ext, bypass_clr, busy_eff;
  logic [CH_W-1:0]    owner_ext [IDX_N];
  logic [CH_N-1:0]    full_ext, flush_ext, ch_ok_ext;
  logic               issue;

  // Index-space views padded to the full encodable range so any index reads safely.
  genvar gi;
  generate
    for (gi = 0; gi < IDX_N; gi++) begin : g_idx
      if (gi < REG_NUM) begin : g_real
        assign busy_ext[gi]  = busy_reg[gi];
        assign owner_ext[gi] = owner_reg[gi];
      end else begin : g_pad
        assign busy_ext[gi]  = 1'b0;
        assign owner_ext[gi] = '0;
      end
    end

    for (gi = 0; gi < LONG_CH; gi++) begin : g_ch
      assign wb_idx[gi]  = wb_rd[gi*IDX_W +: IDX_W];
      assign ch_full[gi] = (count_reg[gi] == CNT_W'(MAX_OUT));
      // Writeback that actually retires a register this channel owns.
      assign wb_own[gi]  = wb_wr[gi] & ~ch_flush[gi] & busy_ext[wb_idx[gi]]
                         & (owner_ext[wb_idx[gi]] == CH_W'(gi));
    end

    for (gi = 0; gi < CH_N; gi++) begin : g_chext
      if (gi < LONG_CH) begin : g_real
        assign full_ext[gi]  = ch_full[gi] & ~dec_now[gi];
        assign flush_ext[gi] = ch_flush[gi];
        assign ch_ok_ext[gi] = 1'b1;
      end else begin : g_pad
        assign full_ext[gi]  = 1'b0;
        assign flush_ext[gi] = 1'b0;
        assign ch_ok_ext[gi] = 1'b0;
      end
    end
  endgenerate

`ifdef SCB_WB_BYPASS_EN
  always_comb begin
    bypass_clr = '0;
    dec_now    = '0;
    for (int k = 0; k < LONG_CH; k++) begin
      if (wb_own[k]) bypass_clr[wb_idx[k]] = 1'b1;
      dec_now[k] = wb_wr[k] & ~ch_flush[k] & (count_reg[k] != '0);
    end
  end
`else
  assign bypass_clr = '0;
  assign dec_now    = '0;
`endif

  assign busy_eff = busy_ext & ~bypass_clr;

  assign conflict = instruction_vld & (
      (rs1_mark & busy_eff[rs1_index])
    | (rs2_mark & busy_eff[rs2_index])
    | ((rd_mark | rd_long_mark) & busy_eff[rd_index])
    | (rd_long_mark & (full_ext[long_ch] | flush_ext[long_ch] | ~ch_ok_ext[long_ch])));

  assign issue = instruction_vld & ~conflict & rd_long_mark;

  always_comb begin
    busy_next = busy_reg;
    for (int r = 0; r < REG_NUM; r++) owner_next[r] = owner_reg[r];
    for (int k = 0; k < LONG_CH; k++) count_next[k] = count_reg[k];

    for (int k = 0; k < LONG_CH; k++) begin
      for (int r = 1; r < REG_NUM; r++) begin
        if (ch_flush[k] && busy_reg[r] && owner_reg[r] == CH_W'(k)) busy_next[r] = 1'b0;
        if (wb_own[k] && wb_idx[k] == IDX_W'(r)) busy_next[r] = 1'b0;
      end
      if (ch_flush[k]) begin
        count_next[k] = '0;
      end else if (issue && long_ch == CH_W'(k) && !wb_wr[k]) begin
        count_next[k] = count_reg[k] + CNT_W'(1);
      end else if (!(issue && long_ch == CH_W'(k)) && wb_wr[k] && count_reg[k] != '0) begin
        count_next[k] = count_reg[k] - CNT_W'(1);
      end
    end

    // Issue is applied last so it wins over a same-cycle clear of the same register.
    for (int r = 1; r < REG_NUM; r++) begin
      if (issue && rd_index == IDX_W'(r)) begin
        busy_next[r]  = 1'b1;
        owner_next[r] = long_ch;
      end
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_reg <= '0;
      for (int r = 0; r < REG_NUM; r++) owner_reg[r] <= '0;
      for (int k = 0; k < LONG_CH; k++) count_reg[k] <= '0;
    end else begin
      busy_reg <= busy_next;
      for (int r = 0; r < REG_NUM; r++) owner_reg[r] <= owner_next[r];
      for (int k = 0; k < LONG_CH; k++) count_reg[k] <= count_next[k];
    end
  end

  assign busy_vec = busy_reg;

endmodule
